// File: rtl/seq_datapath.sv
// rtl/seq_datapath.sv - multi-cycle register-file datapath: read A, read B, execute, write back
module seq_datapath #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int IMM_W = 5,
  localparam int RW = $clog2(NREGS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [1:0]       shift,
  input  logic [RW-1:0]    rd,
  input  logic [RW-1:0]    rn,
  input  logic [RW-1:0]    rm,
  input  logic             use_imm,
  input  logic [IMM_W-1:0] imm,
  input  logic             ext_load,
  input  logic [WIDTH-1:0] ext_data,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             Z,
  output logic             N,
  output logic             V
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_READ_A = 3'd1;
  localparam logic [2:0] S_READ_B = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_WRITE  = 3'd4;

  logic [2:0]       state;
  logic [WIDTH-1:0] regs [NREGS];
  logic [WIDTH-1:0] a, b;
  logic [1:0]       op_q, shift_q;
  logic [RW-1:0]    rd_q, rn_q, rm_q;
  logic             use_imm_q;
  logic [IMM_W-1:0] imm_q;

  logic [WIDTH-1:0] b_sh, b_in, alu;
  logic             ovf;

  // Immediate bypasses the shifter entirely.
  always_comb begin
    b_sh = b;
    case (shift_q)
      2'b01:   b_sh = b << 1;
      2'b10:   b_sh = b >> 1;
      2'b11:   b_sh = {b[WIDTH-1], b[WIDTH-1:1]};
      default: b_sh = b;
    endcase
    b_in = use_imm_q ? {{(WIDTH-IMM_W){1'b0}}, imm_q} : b_sh;
  end

  always_comb begin
    alu = '0;
    ovf = 1'b0;
    case (op_q)
      2'b00: begin
        alu = a + b_in;
        ovf = (a[WIDTH-1] == b_in[WIDTH-1]) && (alu[WIDTH-1] != a[WIDTH-1]);
      end
      2'b01: begin
        alu = a - b_in;
        ovf = (a[WIDTH-1] != b_in[WIDTH-1]) && (alu[WIDTH-1] != a[WIDTH-1]);
      end
      2'b10:   alu = a & b_in;
      default: alu = ~b_in;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      a         <= '0;
      b         <= '0;
      result    <= '0;
      Z         <= 1'b0;
      N         <= 1'b0;
      V         <= 1'b0;
      op_q      <= '0;
      shift_q   <= '0;
      rd_q      <= '0;
      rn_q      <= '0;
      rm_q      <= '0;
      use_imm_q <= 1'b0;
      imm_q     <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_READ_A;
            op_q      <= op;
            shift_q   <= shift;
            rd_q      <= rd;
            rn_q      <= rn;
            rm_q      <= rm;
            use_imm_q <= use_imm;
            imm_q     <= imm;
          end else if (ext_load) begin
            regs[rd] <= ext_data;
          end
        end
        S_READ_A: begin
          a     <= regs[rn_q];
          state <= S_READ_B;
        end
        S_READ_B: begin
          b     <= regs[rm_q];
          state <= S_EXEC;
        end
        S_EXEC: begin
          result <= alu;
          Z      <= (alu == '0);
          N      <= alu[WIDTH-1];
          V      <= ovf;
          state  <= S_WRITE;
        end
        S_WRITE: begin
          regs[rd_q] <= result;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_WRITE);

endmodule
